// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - memory map bounds, region and controller state types
package mem_map_pkg;

    localparam logic [15:0] ROM_LO  = 16'h0000;
    localparam logic [15:0] ROM_HI  = 16'h001f;
    localparam logic [15:0] RAM_LO  = 16'h0800;
    localparam logic [15:0] RAM_HI  = 16'h083f;
    localparam logic [15:0] IO_ADDR = 16'h00fc;

    typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_IO, REG_NONE} region_e;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    // Offset compare so a zero lower bound needs no always-true test
    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        logic [15:0] off;
        logic [15:0] span;
        off  = a - lo;
        span = hi - lo;
        return off <= span;
    endfunction

endpackage

// File: rtl/mem_region_decode.sv
// rtl/mem_region_decode.sv - combinational word address to region decode
module mem_region_decode
    import mem_map_pkg::*;
(
    input  logic [15:0] addr_i,
    output region_e     region_o
);

    always_comb begin
        region_o = REG_NONE;
        if (in_range(addr_i, ROM_LO, ROM_HI)) begin
            region_o = REG_ROM;
        end else if (addr_i == IO_ADDR) begin
            region_o = REG_IO;
        end else if (in_range(addr_i, RAM_LO, RAM_HI)) begin
            region_o = REG_RAM;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/data bus arbiter with per-region wait states
// ARB_ROUND_ROBIN_EN selects round-robin contention; default is data priority.
module mem_bus_arbiter
    import mem_map_pkg::*;
#(
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 2,
    parameter int IO_WAIT  = 1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        gnt_dm_q, gnt_dm_d;
    region_e     region_q, region_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;

    logic        pick_dm;
    logic [15:0] req_addr;
    region_e     req_region;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dm_q, last_dm_d;
    assign pick_dm = dm_req && (!if_req || !last_dm_q);
`else
    assign pick_dm = dm_req;
`endif

    assign req_addr = pick_dm ? dm_addr : if_addr;

    mem_region_decode u_decode (
        .addr_i   (req_addr),
        .region_o (req_region)
    );

    function automatic logic [3:0] wait_of(input region_e r);
        case (r)
            REG_ROM: return 4'(ROM_WAIT);
            REG_RAM: return 4'(RAM_WAIT);
            REG_IO:  return 4'(IO_WAIT);
            default: return 4'd0;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        gnt_dm_d   = gnt_dm_q;
        region_d   = region_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_dm_d  = last_dm_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d   = ACCESS;
                    gnt_dm_d  = pick_dm;
                    addr_d    = req_addr;
                    wdata_d   = pick_dm ? dm_wdata : 32'h0;
                    we_d      = pick_dm && dm_we;
                    region_d  = req_region;
                    cnt_d     = wait_of(req_region);
`ifdef ARB_ROUND_ROBIN_EN
                    last_dm_d = pick_dm;
`endif
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (gnt_dm_q) begin
                            dm_rdata_d = (region_q == REG_NONE) ? 32'h0 : mem_rdata;
                        end else begin
                            if_rdata_d = (region_q == REG_NONE) ? 32'h0 : mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 16'h0;
            wdata_q    <= 32'h0;
            we_q       <= 1'b0;
            gnt_dm_q   <= 1'b0;
            region_q   <= REG_NONE;
            if_rdata_q <= 32'h0;
            dm_rdata_q <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dm_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            gnt_dm_q   <= gnt_dm_d;
            region_q   <= region_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_dm_q  <= last_dm_d;
`endif
        end
    end

    // Decoded from state so an asynchronous reset kills the strobe at once
    assign mem_we    = (state_q == ACCESS) && (cnt_q == 4'd0) && we_q
                       && (region_q != REG_NONE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = (state_q == DONE) && !gnt_dm_q;
    assign dm_ack    = (state_q == DONE) && gnt_dm_q;
    assign bus_err   = (state_q == DONE) && (region_q == REG_NONE);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam int ROM_W = 1;
    localparam int RAM_W = 2;
    localparam int IO_W  = 1;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [15:0] if_addr, dm_addr;
    logic [31:0] dm_wdata, mem_rdata;
    logic        if_ack, dm_ack, mem_we, bus_err;
    logic [31:0] if_rdata, dm_rdata, mem_wdata;
    logic [15:0] mem_addr;

    mem_bus_arbiter #(.ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .IO_WAIT(IO_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_if_rdata = 32'h0;
    logic [31:0] exp_dm_rdata = 32'h0;

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          exp_lat;
        bit          exp_err;
        int          exp_we;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit mapped(input logic [15:0] a);
        return (a < 16'h0020) || (a == 16'h00fc) || (a >= 16'h0800 && a < 16'h0840);
    endfunction

    function automatic int wait_of(input logic [15:0] a);
        if (a < 16'h0020) return ROM_W;
        if (a == 16'h00fc) return IO_W;
        if (a >= 16'h0800 && a < 16'h0840) return RAM_W;
        return 0;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;
        exp_if_rdata = 32'h0;
        exp_dm_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Starts and ends at a negedge with the controller idle
    task automatic do_access(input bit is_dm, input bit we, input logic [15:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int exp_lat, input bit exp_err, input int exp_we);
        int edges = 0;
        int we_cycles = 0;
        bit got = 1'b0;
        mem_rdata = rdata;
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        while (!got && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (mem_we) begin
                we_cycles++;
                check("we_addr", {16'h0, mem_addr}, {16'h0, addr});
                check("we_wdata", mem_wdata, wdata);
            end
            if (is_dm ? dm_ack : if_ack) got = 1'b1;
        end
        check("ack_seen", 32'(got), 32'd1);
        check("latency", edges, exp_lat);
        check("other_ack", 32'(is_dm ? if_ack : dm_ack), 32'd0);
        check("bus_err", 32'(bus_err), 32'(exp_err));
        check("we_cycles", we_cycles, exp_we);
        if (!(is_dm && we)) begin
            if (is_dm) exp_dm_rdata = mapped(addr) ? rdata : 32'h0;
            else       exp_if_rdata = mapped(addr) ? rdata : 32'h0;
        end
        check("if_rdata", if_rdata, exp_if_rdata);
        check("dm_rdata", dm_rdata, exp_dm_rdata);
        if_req = 1'b0;
        dm_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ack_pulse", {30'h0, if_ack, dm_ack}, 32'd0);
        check("err_pulse", 32'(bus_err), 32'd0);
    endtask

    task automatic contention();
        bit last_dm;
        bit exp_dm;
        logic [1:0] acks;
        int cyc;
        apply_reset();
        last_dm = 1'b0;
        mem_rdata = 32'h7777_0001;
        if_req = 1'b1; if_addr = 16'h0005;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0800;
        for (int g = 0; g < 4; g++) begin
            cyc = 0;
            acks = 2'b00;
            while (acks == 2'b00 && cyc < 40) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                acks = {if_ack, dm_ack};
            end
            exp_dm = RR ? !last_dm : 1'b1;
            check("contend_grant", {30'h0, acks}, exp_dm ? 32'd1 : 32'd2);
            check("contend_lat", cyc,
                  wait_of(exp_dm ? dm_addr : if_addr) + 2 + ((g == 0) ? 0 : 1));
            last_dm = exp_dm;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 16'h0005, 32'h0,         32'h1000_001c, 3, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b1, 16'h0800, 32'hffff_fffe, 32'h0,         4, 1'b0, 1};
        tbl[2]  = '{1'b1, 1'b1, 16'h0400, 32'h1234_0000, 32'h0,         2, 1'b1, 0};
        tbl[3]  = '{1'b1, 1'b0, 16'h0400, 32'h0,         32'hdead_beef, 2, 1'b1, 0};
        tbl[4]  = '{1'b1, 1'b1, 16'h00fc, 32'h0000_0004, 32'h0,         3, 1'b0, 1};
        tbl[5]  = '{1'b1, 1'b0, 16'h00fc, 32'h0,         32'h1234_5678, 3, 1'b0, 0};
        tbl[6]  = '{1'b0, 1'b0, 16'h083f, 32'h0,         32'ha5a5_5a5a, 4, 1'b0, 0};
        tbl[7]  = '{1'b0, 1'b0, 16'h0840, 32'h0,         32'h0bad_0bad, 2, 1'b1, 0};
        tbl[8]  = '{1'b1, 1'b0, 16'h001f, 32'h0,         32'hcafe_f00d, 3, 1'b0, 0};
        tbl[9]  = '{1'b0, 1'b0, 16'h0020, 32'h0,         32'h5555_aaaa, 2, 1'b1, 0};
        tbl[10] = '{1'b1, 1'b1, 16'h07ff, 32'h0f0f_0f0f, 32'h0,         2, 1'b1, 0};
        tbl[11] = '{1'b1, 1'b0, 16'h0800, 32'h0,         32'h0bad_f00d, 4, 1'b0, 0};

        rst = 1'b1;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_flags", {28'h0, mem_we, if_ack, dm_ack, bus_err}, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            do_access(tbl[i].is_dm, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
                      tbl[i].exp_lat, tbl[i].exp_err, tbl[i].exp_we);
        end

        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic [15:0] edge_list [6];
            bit is_dm, we;
            edge_list = '{16'h0020, 16'h07ff, 16'h0840, 16'h00fb, 16'h00fd, 16'hffff};
            case ($urandom_range(0, 5))
                0:       a = 16'($urandom_range(0, 31));
                1:       a = 16'h00fc;
                2:       a = 16'h0800 + 16'($urandom_range(0, 63));
                3:       a = 16'($urandom);
                4:       a = edge_list[$urandom_range(0, 5)];
                default: a = 16'h001f;
            endcase
            is_dm = 1'($urandom_range(0, 1));
            we    = is_dm && 1'($urandom_range(0, 1));
            do_access(is_dm, we, a, $urandom, $urandom, wait_of(a) + 2, !mapped(a),
                      (we && mapped(a)) ? 1 : 0);
        end

        contention();

        for (int k = 2; k <= 3; k++) begin
            dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0810;
            dm_wdata = 32'h5a5a_0000 | 32'(k);
            @(posedge clk);
            for (int j = 1; j < k; j++) @(posedge clk);
            #2;
            check("rst_pre_we", 32'(mem_we), (k == 3) ? 32'd1 : 32'd0);
            rst = 1'b1;
            #1;
            check("rst_we_drop", 32'(mem_we), 32'd0);
            check("rst_addr_clr", {16'h0, mem_addr}, 32'h0);
            dm_req = 1'b0;
            exp_if_rdata = 32'h0;
            exp_dm_rdata = 32'h0;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                check("rst_no_ack", {30'h0, if_ack, dm_ack}, 32'd0);
            end
            rst = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check("post_rst_quiet", {29'h0, dm_ack, bus_err, mem_we}, 32'd0);
            end
            do_access(1'b1, 1'b0, 16'h0810, 32'h0, 32'h6060_0000 | 32'(k), 4, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
